bullet_scan: RTL and testbench

BULLET_SCAN -- requirements
Module: bullet_scan

---
 rtl/bullet_scan.sv | 115 +++++++++++
 tb/tb_bullet_scan.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bullet_scan.sv
// bullet_scan: sequentially scans a bullet table against a latched player box through an external checker.
// Ports: clk/rst (sync, active-high); start launches a scan; px/py/lpx/lpy player centre and size;
// wr_* write one table entry; check is the checker result for chk_p*/chk_b*;
// busy/done scan status; hit_mask/hit_count/first_hit/any_hit results of the last scan.
// Option: define BULLET_CLEAR_ON_HIT_EN to invalidate an entry when it is hit.
module bullet_scan #(
  parameter int NUM_BULLETS = 8,
  parameter int IDX_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             px,
  input  logic [7:0]             py,
  input  logic [7:0]             lpx,
  input  logic [7:0]             lpy,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_x,
  input  logic [7:0]             wr_y,
  input  logic [7:0]             wr_w,
  input  logic [7:0]             wr_h,
  input  logic                   check,
  output logic [7:0]             chk_px,
  output logic [7:0]             chk_py,
  output logic [7:0]             chk_lpx,
  output logic [7:0]             chk_lpy,
  output logic [7:0]             chk_bx,
  output logic [7:0]             chk_by,
  output logic [7:0]             chk_lbx,
  output logic [7:0]             chk_lby,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_BULLETS-1:0] hit_mask,
  output logic [IDX_W:0]         hit_count,
  output logic [IDX_W-1:0]       first_hit,
  output logic                   any_hit
);
  typedef enum logic [1:0] {IDLE, ISSUE, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [7:0] px_q, py_q, lpx_q, lpy_q;
  logic [NUM_BULLETS-1:0] valid_q;
  logic [7:0] bx_q [NUM_BULLETS];
  logic [7:0] by_q [NUM_BULLETS];
  logic [7:0] bw_q [NUM_BULLETS];
  logic [7:0] bh_q [NUM_BULLETS];
  logic last, cur_valid, advance, hit;
  assign last = idx_q == IDX_W'(NUM_BULLETS - 1);
  assign cur_valid = valid_q[idx_q];
  assign advance = (state_q == ISSUE && !cur_valid) || state_q == SAMPLE;
  assign hit = state_q == SAMPLE && check;
  assign busy = state_q == ISSUE || state_q == SAMPLE;
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE  ? (start ? ISSUE : IDLE) :
              state_q == ISSUE ? (cur_valid ? SAMPLE : (last ? DONE : ISSUE)) :
              state_q == SAMPLE ? (last ? DONE : ISSUE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      hit_mask  <= '0;
      hit_count <= '0;
      first_hit <= '0;
      any_hit   <= 1'b0;
      {px_q, py_q, lpx_q, lpy_q} <= '0;
      {chk_px, chk_py, chk_lpx, chk_lpy} <= '0;
      {chk_bx, chk_by, chk_lbx, chk_lby} <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        {px_q, py_q, lpx_q, lpy_q} <= {px, py, lpx, lpy};
        hit_mask  <= '0;
        hit_count <= '0;
        first_hit <= '0;
        any_hit   <= 1'b0;
        idx_q     <= '0;
      end
      if (state_q == ISSUE && cur_valid) begin
        {chk_px, chk_py, chk_lpx, chk_lpy} <= {px_q, py_q, lpx_q, lpy_q};
        {chk_bx, chk_by, chk_lbx, chk_lby} <= {bx_q[idx_q], by_q[idx_q], bw_q[idx_q], bh_q[idx_q]};
      end
      if (advance && !last) idx_q <= idx_q + 1'b1;
      if (hit) begin
        hit_mask[idx_q] <= 1'b1;
        hit_count       <= hit_count + 1'b1;
        if (!any_hit) begin
          first_hit <= idx_q;
          any_hit   <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else begin
`ifdef BULLET_CLEAR_ON_HIT_EN
      if (hit) valid_q[idx_q] <= 1'b0;
`endif
      if (wr_en) valid_q[wr_idx] <= wr_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      bx_q[wr_idx] <= wr_x;
      by_q[wr_idx] <= wr_y;
      bw_q[wr_idx] <= wr_w;
      bh_q[wr_idx] <= wr_h;
    end
  end
endmodule

// File: tb/tb_bullet_scan.sv
// tb_bullet_scan: vector table plus scoreboard checks of bullet_scan with a behavioural overlap checker.
module tb_bullet_scan;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, wr_en = 1'b0, wr_valid = 1'b0, check;
  logic [7:0] px = 8'd80, py = 8'd60, lpx = 8'd16, lpy = 8'd16;
  logic [7:0] wr_x = '0, wr_y = '0, wr_w = '0, wr_h = '0;
  logic [2:0] wr_idx = '0;
  logic [7:0] chk_px, chk_py, chk_lpx, chk_lpy, chk_bx, chk_by, chk_lbx, chk_lby;
  logic busy, done, any_hit;
  logic [7:0] hit_mask;
  logic [3:0] hit_count;
  logic [2:0] first_hit;
  int total = 0, bad = 0;

  typedef struct {
    logic [7:0] vm;
    logic [7:0] gm;
    logic [7:0] mask;
    int cnt;
    int first;
    int any;
    int lat;
  } vec_t;
  vec_t q[$];

  bullet_scan dut (
    .clk(clk), .rst(rst), .start(start), .px(px), .py(py), .lpx(lpx), .lpy(lpy),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y),
    .wr_w(wr_w), .wr_h(wr_h), .check(check),
    .chk_px(chk_px), .chk_py(chk_py), .chk_lpx(chk_lpx), .chk_lpy(chk_lpy),
    .chk_bx(chk_bx), .chk_by(chk_by), .chk_lbx(chk_lbx), .chk_lby(chk_lby),
    .busy(busy), .done(done), .hit_mask(hit_mask), .hit_count(hit_count),
    .first_hit(first_hit), .any_hit(any_hit)
  );

  always #5 clk = ~clk;

  function automatic logic ovl(input logic [7:0] a, input logic [7:0] b, input logic [7:0] la, input logic [7:0] lb);
    int d;
    d = a > b ? int'(a) - int'(b) : int'(b) - int'(a);
    return 2 * d < int'(la) + int'(lb);
  endfunction

  assign check = ovl(chk_px, chk_bx, chk_lpx, chk_lbx) && ovl(chk_py, chk_by, chk_lpy, chk_lby);

  task automatic cmp(input string n, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic wr(input int i, input logic v, input logic ov);
    wr_en = 1'b1;
    wr_idx = i[2:0];
    wr_valid = v;
    {wr_x, wr_y, wr_w, wr_h} = ov ? {8'd84, 8'd62, 8'd4, 8'd4} : {8'd200, 8'd200, 8'd4, 8'd4};
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [7:0] vm, input logic [7:0] gm);
    for (int i = 0; i < 8; i++) wr(i, vm[i], gm[i]);
  endtask

  task automatic scan(input vec_t e, input int mid);
    vec_t r;
    int lat;
    start = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    cmp("busy_after_accept", busy, 1);
    if (mid >= 0) begin
      wr(mid, 1'b1, 1'b1);
      lat = 2;
    end
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = q.pop_front();
    if (!done) cmp("done_timeout", done, 1);
    else begin
      cmp("hit_mask", hit_mask, r.mask);
      cmp("hit_count", hit_count, r.cnt);
      cmp("first_hit", first_hit, r.first);
      cmp("any_hit", any_hit, r.any);
      cmp("latency", lat, r.lat);
      cmp("busy_at_done", busy, 0);
      @(negedge clk);
      cmp("done_one_cycle", done, 0);
      cmp("mask_hold", hit_mask, r.mask);
    end
  endtask

  initial begin
    vec_t v[7];
    vec_t v2;
    int n, d1, d2, dones;
    v[0] = '{8'h00, 8'h00, 8'h00, 0, 0, 0, 9};
    v[1] = '{8'h24, 8'h04, 8'h04, 1, 2, 1, 11};
    v[2] = '{8'hFF, 8'hFF, 8'hFF, 8, 0, 1, 17};
    v[3] = '{8'hF0, 8'hA0, 8'hA0, 2, 5, 1, 13};
    v[4] = '{8'h81, 8'h80, 8'h80, 1, 7, 1, 11};
    v[5] = '{8'h0F, 8'h00, 8'h00, 0, 0, 0, 13};
    v[6] = '{8'h00, 8'hFF, 8'h00, 0, 0, 0, 9};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp("rst_busy", busy, 0);
    cmp("rst_done", done, 0);
    cmp("rst_mask", hit_mask, 0);
    cmp("rst_count", hit_count, 0);
    cmp("rst_any", any_hit, 0);
    cmp("rst_chk", {chk_px, chk_bx, chk_lby}, 0);
    for (int i = 0; i < 7; i++) begin
      load(v[i].vm, v[i].gm);
      scan(v[i], -1);
    end
    // entry written during the scan must be picked up at its ISSUE
    load(8'h00, 8'h00);
    v2 = '{8'h00, 8'h00, 8'h20, 1, 5, 1, 10};
    scan(v2, 5);
    // repeated scan: clear-on-hit drops entry 2 the second time
    load(8'h24, 8'h04);
    scan(v[1], -1);
`ifdef BULLET_CLEAR_ON_HIT_EN
    v2 = '{8'h00, 8'h00, 8'h00, 0, 0, 0, 10};
`else
    v2 = v[1];
`endif
    scan(v2, -1);
    // start held high: one done per scan, re-accepted the cycle after done
    load(8'h00, 8'h00);
    start = 1'b1;
    d1 = 0;
    d2 = 0;
    dones = 0;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) d1 = i;
        else d2 = i;
      end
    end
    start = 1'b0;
    cmp("held_dones", dones, 2);
    cmp("held_done1", d1, 9);
    cmp("held_done2", d2, 19);
    @(negedge clk);
    cmp("held_idle", busy, 0);
    // reset during SAMPLE of entry 3
    load(8'hFF, 8'hFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    cmp("pre_rst_mask", hit_mask, 8'h07);
    cmp("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("mid_rst_busy", busy, 0);
    cmp("mid_rst_mask", hit_mask, 0);
    cmp("mid_rst_count", hit_count, 0);
    cmp("mid_rst_first", first_hit, 0);
    cmp("mid_rst_any", any_hit, 0);
    cmp("mid_rst_chk", {chk_px, chk_py, chk_bx, chk_by}, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) n++;
    end
    cmp("no_done_after_rst", n, 0);
    scan(v[0], -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
